// File: rtl/seq_multiplier.sv
// Radix-2 shift-add multiplier for the HI/LO unit.
// One multiplier bit per clock; signed and unsigned modes.
module seq_multiplier #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               signed_op,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic               neg;

    logic               accept;
    logic               last;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] acc_nxt;

    // Magnitudes are unsigned WIDTH bits so -2^(WIDTH-1) still fits.
    always_comb begin
        accept = start && (state != RUN);
        last   = (state == RUN) && (cnt == CW'(WIDTH - 1));
        abs_a  = multiplicand;
        abs_b  = multiplier;
        if (signed_op && multiplicand[WIDTH-1])
            abs_a = ~multiplicand + WIDTH'(1);
        if (signed_op && multiplier[WIDTH-1])
            abs_b = ~multiplier + WIDTH'(1);
        addend  = mag_b[0] ? mag_a : '0;
        sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
        acc_nxt = {sum, acc[WIDTH-1:1]};
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic; FIN lasts one cycle and may chain into RUN.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last) state_nxt = FIN;
            FIN:     state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Status outputs decode directly from the registered state.
    always_comb begin
        busy = (state == RUN);
        done = (state == FIN);
    end

    // Datapath: load on accept, shift-add while running, publish on last.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            acc     <= '0;
            mag_a   <= '0;
            mag_b   <= '0;
            neg     <= 1'b0;
            product <= '0;
        end else if (accept) begin
            neg   <= signed_op &
                     (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
            mag_a <= abs_a;
            mag_b <= abs_b;
            acc   <= '0;
            cnt   <= '0;
        end else if (state == RUN) begin
            acc   <= acc_nxt;
            mag_b <= mag_b >> 1;
            cnt   <= cnt + CW'(1);
            if (last)
                product <= neg ? (~acc_nxt + (2*WIDTH)'(1)) : acc_nxt;
        end
    end

endmodule
